// File: rtl/instruction_fetch.sv
// Instruction fetch front end: PC register, instruction-memory request
// generation, one-entry hold buffer for decode stalls and redirect flushing.
// Words are presented in strict PC order, one per cycle in steady state.
module instruction_fetch #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    output logic            instr_valid,
    output logic [15:0]     instr,
    output logic [PC_W-1:0] instr_pc
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    // Control state (reset) and payload state (not reset).
    logic            ir_valid_q, ir_valid_d;
    logic [15:0]     ir_q, ir_d;
    logic [PC_W-1:0] ir_pc_q, ir_pc_d;
    logic            hold_valid_q, hold_valid_d;
    logic [15:0]     hold_q, hold_d;
    logic [PC_W-1:0] hold_pc_q, hold_pc_d;
    logic            inflight_q, inflight_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [PC_W-1:0] next_pc_q, next_pc_d;

    logic            deq;
    logic            issue;
    logic [2:0]      occ;

    // Issue decision, response routing and IR/hold refill.
    // NOTE: every _d gets a default first so no path through this block
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        deq   = ir_valid_q && !stall;
        // Words held or on their way after this edge; deq implies ir_valid_q,
        // so the subtraction cannot underflow.
        occ   = 3'(ir_valid_q) + 3'(hold_valid_q) + 3'(inflight_q) - 3'(deq);
        issue = rst_n && !redirect_valid && (occ < 3'd2);

        ir_valid_d    = ir_valid_q;
        ir_d          = ir_q;
        ir_pc_d       = ir_pc_q;
        hold_valid_d  = hold_valid_q;
        hold_d        = hold_q;
        hold_pc_d     = hold_pc_q;
        inflight_d    = issue;
        inflight_pc_d = next_pc_q;
        next_pc_d     = next_pc_q;

        if (redirect_valid) begin
            // Flush everything; the response due next cycle is orphaned.
            ir_valid_d   = 1'b0;
            hold_valid_d = 1'b0;
            inflight_d   = 1'b0;
            next_pc_d    = redirect_pc;
        end else begin
            if (issue) begin
                next_pc_d = next_pc_q + PC_ONE;
            end
            if (deq) begin
                if (hold_valid_q) begin
                    // Oldest word is in hold; an arriving word takes its place.
                    ir_d         = hold_q;
                    ir_pc_d      = hold_pc_q;
                    hold_valid_d = inflight_q;
                    if (inflight_q) begin
                        hold_d    = imem_rdata;
                        hold_pc_d = inflight_pc_q;
                    end
                end else if (inflight_q) begin
                    ir_d    = imem_rdata;
                    ir_pc_d = inflight_pc_q;
                end else begin
                    ir_valid_d = 1'b0;
                end
            end else if (inflight_q) begin
                if (!ir_valid_q) begin
                    ir_valid_d = 1'b1;
                    ir_d       = imem_rdata;
                    ir_pc_d    = inflight_pc_q;
                end else begin
                    hold_valid_d = 1'b1;
                    hold_d       = imem_rdata;
                    hold_pc_d    = inflight_pc_q;
                end
            end
        end
    end

    // Control state register with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_valid_q   <= 1'b0;
            ir_q         <= 16'h0000;
            ir_pc_q      <= '0;
            hold_valid_q <= 1'b0;
            inflight_q   <= 1'b0;
            next_pc_q    <= RESET_PC;
        end else begin
            ir_valid_q   <= ir_valid_d;
            ir_q         <= ir_d;
            ir_pc_q      <= ir_pc_d;
            hold_valid_q <= hold_valid_d;
            inflight_q   <= inflight_d;
            next_pc_q    <= next_pc_d;
        end
    end

    // Hold and in-flight payload registers.
    // NOTE: payloads are left unreset; their valid flags gate every use.
    always_ff @(posedge clk) begin
        hold_q        <= hold_d;
        hold_pc_q     <= hold_pc_d;
        inflight_pc_q <= inflight_pc_d;
    end

    assign imem_en     = issue;
    assign imem_addr   = next_pc_q;
    assign instr_valid = ir_valid_q;
    assign instr       = ir_q;
    assign instr_pc    = ir_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed test-plan scenarios
// followed by randomized stall/redirect/reset traffic, all checked against
// an in-order PC-stream reference model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_en, instr_valid;
    logic [15:0] imem_addr, imem_rdata, instr, instr_pc;
    logic        b_imem_en, b_instr_valid;
    logic [15:0] b_imem_addr, b_imem_rdata, b_instr, b_instr_pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instruction_fetch u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
    );

    instruction_fetch #(.PC_W(16), .RESET_PC(16'hFFFE)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_pc(16'h0000),
        .imem_en(b_imem_en), .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata),
        .instr_valid(b_instr_valid), .instr(b_instr), .instr_pc(b_instr_pc)
    );

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    // Synchronous memories: data one cycle after the request, garbage otherwise.
    always @(posedge clk) begin
        imem_rdata   <= imem_en   ? mem_f(imem_addr)   : 16'($urandom);
        b_imem_rdata <= b_imem_en ? mem_f(b_imem_addr) : 16'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the delivered stream is RESET_PC, +1, +1 ... restarted
    // at redirect_pc on a redirect and at RESET_PC on reset; requests follow
    // the same rule; a stalled live word is frozen; no bubble run exceeds 3.
    bit          sb_on = 1'b0;
    bit          hold_chk = 1'b0;
    logic [15:0] exp_pc, req_pc, h_instr, h_pc;
    int          idle = 0;

    always @(negedge clk) begin
        if (sb_on) begin
            if (rst_n !== 1'b1) begin
                check("en_in_reset", imem_en, 0);
                exp_pc   = 16'h0000;
                req_pc   = 16'h0000;
                hold_chk = 1'b0;
                idle     = 0;
            end else begin
                if (hold_chk) begin
                    check("stall_valid", instr_valid, 1);
                    check("stall_instr", instr, h_instr);
                    check("stall_pc", instr_pc, h_pc);
                end
                if (redirect_valid === 1'b1) begin
                    check("en_on_redirect", imem_en, 0);
                end else if (imem_en === 1'b1) begin
                    check("req_addr", imem_addr, req_pc);
                    req_pc = req_pc + 16'h1;
                end
                if (instr_valid === 1'b1 && stall === 1'b0) begin
                    check("deq_pc", instr_pc, exp_pc);
                    check("deq_instr", instr, mem_f(exp_pc));
                    exp_pc = exp_pc + 16'h1;
                    idle   = 0;
                end else if (stall === 1'b0) begin
                    idle++;
                    check("bubble_bound", idle > 3, 0);
                end
                if (redirect_valid === 1'b1) begin
                    exp_pc = redirect_pc;
                    req_pc = redirect_pc;
                    idle   = 0;
                end
                hold_chk = (instr_valid === 1'b1) && stall && !redirect_valid;
                h_instr  = instr;
                h_pc     = instr_pc;
            end
        end
    end

    initial begin
        int          en_cnt;
        logic [15:0] bpc;
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
        sb_on = 1'b1;
        repeat (3) step();

        // Reset release, streaming with no stall.
        rst_n = 1'b1;
        @(negedge clk);
        check("c1_en", imem_en, 1);
        check("c1_addr", imem_addr, 16'h0000);
        check("c1_valid", instr_valid, 0);
        check("wrap_c1_addr", b_imem_addr, 16'hFFFE);
        step(); @(negedge clk);
        check("c2_valid", instr_valid, 0);
        check("wrap_c2_valid", b_instr_valid, 0);
        for (int i = 0; i < 2; i++) begin
            step(); @(negedge clk);
            bpc = 16'hFFFE + 16'(i);
            check("stream_valid", instr_valid, 1);
            check("stream_pc", instr_pc, 16'(i));
            check("stream_instr", instr, 16'h1000 + 16'(i));
            check("wrap_valid", b_instr_valid, 1);
            check("wrap_pc", b_instr_pc, bpc);
            check("wrap_instr", b_instr, mem_f(bpc));
        end

        // Stall for three cycles while 0x1002 is presented.
        step(); stall = 1'b1;
        en_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            @(negedge clk);
            check("stall_hold_instr", instr, 16'h1002);
            check("stall_hold_pc", instr_pc, 16'h0002);
            if (k == 0) begin
                check("wrap_pc_0000", b_instr_pc, 16'h0000);
                check("wrap_instr_0000", b_instr, mem_f(16'h0000));
            end
            en_cnt += int'(imem_en);
        end
        check("stall_en_count_le1", en_cnt <= 1, 1);
        step(); stall = 1'b0;
        @(negedge clk); check("release_instr", instr, 16'h1002);
        step(); @(negedge clk);
        check("release_next_valid", instr_valid, 1);
        check("release_next", instr, 16'h1003);
        step(); @(negedge clk);
        check("release_next2", instr, 16'h1004);

        // Redirect to 0x0040 while streaming.
        step(); redirect_valid = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk); check("redir_en", imem_en, 0);
        step(); redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_req_en", imem_en, 1);
        check("redir_req_addr", imem_addr, 16'h0040);
        check("redir_t1_valid", instr_valid, 0);
        step(); @(negedge clk); check("redir_t2_valid", instr_valid, 0);
        step(); @(negedge clk);
        check("redir_t3_valid", instr_valid, 1);
        check("redir_t3_pc", instr_pc, 16'h0040);
        check("redir_t3_instr", instr, 16'h1040);

        // Redirect while stalled with the hold buffer full.
        step(); stall = 1'b1;
        step();
        step(); redirect_valid = 1'b1; redirect_pc = 16'h0080;
        @(negedge clk); check("sredir_en", imem_en, 0);
        step(); redirect_valid = 1'b0; stall = 1'b0;
        @(negedge clk); check("sredir_t1_valid", instr_valid, 0);
        step(); @(negedge clk); check("sredir_t2_valid", instr_valid, 0);
        step(); @(negedge clk);
        check("sredir_pc", instr_pc, 16'h0080);
        check("sredir_instr", instr, 16'h1080);

        // One-cycle reset mid-stream while stalled.
        step(); stall = 1'b1;
        step(); rst_n = 1'b0;
        @(negedge clk); check("mrst_en", imem_en, 0);
        step(); rst_n = 1'b1; stall = 1'b0;
        @(negedge clk);
        check("mrst_valid", instr_valid, 0);
        check("mrst_en_after", imem_en, 1);
        check("mrst_addr", imem_addr, 16'h0000);
        step(); step(); @(negedge clk);
        check("mrst_first_valid", instr_valid, 1);
        check("mrst_first_pc", instr_pc, 16'h0000);

        // Randomized traffic checked by the reference model.
        for (int c = 0; c < 3000; c++) begin
            step();
            stall          = ($urandom_range(0, 9) < 3);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                         : 16'($urandom);
            rst_n          = ($urandom_range(0, 99) != 0);
        end
        step();
        rst_n = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
